// File: rtl/matrix_frame_scheduler_if.sv
// Request/response bundle between the pixel requesters, the frame scheduler and the serializer.
// The scheduler takes the slave modport; stimulus or upstream logic takes master.
interface matrix_frame_scheduler_if;
   logic              g_valid;
   logic [3:0]        g_x;
   logic [3:0]        g_y;
   logic              g_val;
   logic              g_ready;
   logic              o_valid;
   logic [3:0]        o_x;
   logic [3:0]        o_y;
   logic              o_val;
   logic              o_ready;
   logic              clear_req;
   logic              commit_req;
   logic              frame_done;
   logic              commit_ack;
   logic              busy;
   logic [15:0][15:0] grid_out;

   modport master (
      output g_valid, g_x, g_y, g_val,
      output o_valid, o_x, o_y, o_val,
      output clear_req, commit_req, frame_done,
      input  g_ready, o_ready, commit_ack, busy, grid_out
   );

   modport slave (
      input  g_valid, g_x, g_y, g_val,
      input  o_valid, o_x, o_y, o_val,
      input  clear_req, commit_req, frame_done,
      output g_ready, o_ready, commit_ack, busy, grid_out
   );
endinterface

// File: rtl/matrix_frame_scheduler.sv
// Double-buffered 16x16 frame owner: arbitrates game/overlay pixel writes into the back buffer,
// sequences clears, and swaps back to front only at a serializer frame boundary (or on timeout).
module matrix_frame_scheduler #(
   parameter int unsigned SWAP_TIMEOUT = 4096
) (
   input logic                   clk,
   input logic                   reset,
   matrix_frame_scheduler_if.slave bus
);

   localparam int unsigned TW = $clog2(SWAP_TIMEOUT + 1);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] CLEAR     = 2'd1;
   localparam logic [1:0] WAIT_SWAP = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [3:0]        row_q, row_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic [TW-1:0]     tmo_inc;
   logic              pending_q, pending_d;
   logic              last_grant_q;  // 1 = overlay was granted most recently
   logic              ack_q;
   logic              swap;
   logic [15:0][15:0] back_q;
   logic [15:0][15:0] grid_q;

   logic idle;
   logic accept;
   logic g_grant;
   logic o_grant;

   assign idle    = (state_q == IDLE);
   // Gated by reset so both readies drop the instant reset asserts.
   assign accept  = reset & idle & ~bus.clear_req & ~bus.commit_req;
   assign g_grant = accept & bus.g_valid & (~bus.o_valid | last_grant_q);
   assign o_grant = accept & bus.o_valid & (~bus.g_valid | ~last_grant_q);
   assign tmo_inc = tmo_q + TW'(1);

   assign bus.g_ready    = g_grant;
   assign bus.o_ready    = o_grant;
   assign bus.commit_ack = ack_q;
   assign bus.busy       = ~idle | pending_q;
   assign bus.grid_out   = grid_q;

   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      tmo_d     = tmo_q;
      pending_d = pending_q | (bus.commit_req & ~idle);
      swap      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.clear_req) begin
               state_d = CLEAR;
               row_d   = 4'd0;
               if (bus.commit_req) pending_d = 1'b1;
            end else if (bus.commit_req || pending_q) begin
               state_d   = WAIT_SWAP;
               tmo_d     = '0;
               pending_d = 1'b0;
            end
         end
         CLEAR: begin
            row_d = row_q + 4'd1;
            if (row_q == 4'd15) begin
               // A commit queued behind the clear goes straight to the swap wait.
               if (pending_d) begin
                  state_d   = WAIT_SWAP;
                  tmo_d     = '0;
                  pending_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         WAIT_SWAP: begin
            tmo_d = tmo_inc;
            if (bus.frame_done || (tmo_inc == TW'(SWAP_TIMEOUT))) begin
               swap    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         row_q        <= 4'd0;
         tmo_q        <= '0;
         pending_q    <= 1'b0;
         last_grant_q <= 1'b1;
         ack_q        <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         tmo_q     <= tmo_d;
         pending_q <= pending_d;
         ack_q     <= swap;
         if (g_grant) begin
            last_grant_q <= 1'b0;
         end else if (o_grant) begin
            last_grant_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         back_q <= '0;
      end else if (state_q == CLEAR) begin
         back_q[row_q] <= 16'h0000;
      end else begin
         if (g_grant) back_q[bus.g_y][bus.g_x] <= bus.g_val;
         if (o_grant) back_q[bus.o_y][bus.o_x] <= bus.o_val;
      end
   end

   // The back buffer is kept after a swap so drawing can continue incrementally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grid_q <= '0;
      end else if (swap) begin
         grid_q <= back_q;
      end
   end

   a_one_ready: assert property (@(posedge clk) disable iff (!reset)
      !(bus.g_ready && bus.o_ready));

   a_ack_pulse: assert property (@(posedge clk) disable iff (!reset)
      bus.commit_ack |=> !bus.commit_ack);

endmodule

// File: tb/tb_matrix_frame_scheduler.sv
// Self-checking bench: vector table, directed corner sequences and randomized traffic
// compared against a behavioural frame model.
module tb_matrix_frame_scheduler;

   localparam int unsigned TMO_A = 4096;
   localparam int unsigned TMO_B = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   matrix_frame_scheduler_if bus_a ();
   matrix_frame_scheduler_if bus_b ();

   matrix_frame_scheduler #(.SWAP_TIMEOUT(TMO_A)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   matrix_frame_scheduler #(.SWAP_TIMEOUT(TMO_B)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   int checks   = 0;
   int failures = 0;

   // Behavioural model of dut_a
   logic [15:0][15:0] m_back, m_grid;
   int                clear_left;
   bit                waiting;
   int unsigned       wait_age;
   bit                pending, last_o, m_ack;
   bit                eg, eo;

   typedef struct {
      logic       gv;
      logic [3:0] gx, gy;
      logic       gval;
      logic       ov;
      logic [3:0] ox, oy;
      logic       oval;
      logic       eg, eo;
   } vec_t;

   vec_t vecs[9];

   function automatic vec_t mk(input logic gv, input logic [3:0] gx, input logic [3:0] gy,
                               input logic gval, input logic ov, input logic [3:0] ox,
                               input logic [3:0] oy, input logic oval, input logic e_g,
                               input logic e_o);
      vec_t v;
      v.gv = gv; v.gx = gx; v.gy = gy; v.gval = gval;
      v.ov = ov; v.ox = ox; v.oy = oy; v.oval = oval;
      v.eg = e_g; v.eo = e_o;
      return v;
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chkg(input string name, input logic [15:0][15:0] act,
                       input logic [15:0][15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_back     = '0;
      m_grid     = '0;
      clear_left = 0;
      waiting    = 1'b0;
      wait_age   = 0;
      pending    = 1'b0;
      last_o     = 1'b1;
      m_ack      = 1'b0;
   endtask

   task automatic model_eval();
      bit idle, acc;
      idle = (clear_left == 0) && !waiting;
      acc  = reset && idle && !bus_a.clear_req && !bus_a.commit_req;
      eg   = acc && bus_a.g_valid && (!bus_a.o_valid || last_o);
      eo   = acc && bus_a.o_valid && (!bus_a.g_valid || !last_o);
   endtask

   task automatic model_update();
      bit         idle, nack;
      logic [3:0] r;
      idle = (clear_left == 0) && !waiting;
      nack = 1'b0;
      if (eg) begin m_back[bus_a.g_y][bus_a.g_x] = bus_a.g_val; last_o = 1'b0; end
      if (eo) begin m_back[bus_a.o_y][bus_a.o_x] = bus_a.o_val; last_o = 1'b1; end
      if (idle) begin
         if (bus_a.clear_req) begin
            clear_left = 16;
            if (bus_a.commit_req) pending = 1'b1;
         end else if (bus_a.commit_req || pending) begin
            waiting = 1'b1; wait_age = 0; pending = 1'b0;
         end
      end else if (clear_left > 0) begin
         r = 4'(16 - clear_left);
         m_back[r] = 16'h0000;
         clear_left--;
         if (bus_a.commit_req) pending = 1'b1;
         if (clear_left == 0 && pending) begin
            waiting = 1'b1; wait_age = 0; pending = 1'b0;
         end
      end else begin
         if (bus_a.commit_req) pending = 1'b1;
         wait_age++;
         if (bus_a.frame_done || wait_age == TMO_A) begin
            m_grid  = m_back;
            nack    = 1'b1;
            waiting = 1'b0;
         end
      end
      m_ack = nack;
   endtask

   // Called at a negedge with inputs set; compares, advances the model, returns at next negedge.
   task automatic step();
      #1;
      model_eval();
      chk1("g_ready", bus_a.g_ready, eg);
      chk1("o_ready", bus_a.o_ready, eo);
      chk1("busy", bus_a.busy, (clear_left != 0) || waiting || pending);
      chk1("commit_ack", bus_a.commit_ack, m_ack);
      chkg("grid_out", bus_a.grid_out, m_grid);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle_a();
      bus_a.g_valid = 1'b0; bus_a.g_x = 4'd0; bus_a.g_y = 4'd0; bus_a.g_val = 1'b0;
      bus_a.o_valid = 1'b0; bus_a.o_x = 4'd0; bus_a.o_y = 4'd0; bus_a.o_val = 1'b0;
      bus_a.clear_req = 1'b0; bus_a.commit_req = 1'b0; bus_a.frame_done = 1'b0;
   endtask

   task automatic idle_b();
      bus_b.g_valid = 1'b0; bus_b.g_x = 4'd0; bus_b.g_y = 4'd0; bus_b.g_val = 1'b0;
      bus_b.o_valid = 1'b0; bus_b.o_x = 4'd0; bus_b.o_y = 4'd0; bus_b.o_val = 1'b0;
      bus_b.clear_req = 1'b0; bus_b.commit_req = 1'b0; bus_b.frame_done = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end

   initial begin
      logic [15:0][15:0] exp_grid;
      bit                g_hold, o_hold;
      int                first, acks;

      reset = 1'b0;
      idle_a();
      idle_b();
      model_reset();
      bus_a.g_valid = 1'b1;
      #2;
      chk1("rst_g_ready", bus_a.g_ready, 1'b0);
      chk1("rst_busy", bus_a.busy, 1'b0);
      chk1("rst_ack", bus_a.commit_ack, 1'b0);
      chkg("rst_grid", bus_a.grid_out, '0);
      repeat (2) @(negedge clk);
      bus_a.g_valid = 1'b0;
      reset = 1'b1;

      // Arbitration table; first tie after reset goes to game
      vecs[0] = mk(1'b1, 4'd1,  4'd1,  1'b1, 1'b1, 4'd2,  4'd2,  1'b1, 1'b1, 1'b0);
      vecs[1] = mk(1'b1, 4'd3,  4'd3,  1'b1, 1'b1, 4'd2,  4'd2,  1'b1, 1'b0, 1'b1);
      vecs[2] = mk(1'b1, 4'd3,  4'd3,  1'b1, 1'b1, 4'd4,  4'd4,  1'b1, 1'b1, 1'b0);
      vecs[3] = mk(1'b0, 4'd0,  4'd0,  1'b0, 1'b1, 4'd4,  4'd4,  1'b1, 1'b0, 1'b1);
      vecs[4] = mk(1'b1, 4'd3,  4'd5,  1'b1, 1'b0, 4'd0,  4'd0,  1'b0, 1'b1, 1'b0);
      vecs[5] = mk(1'b0, 4'd0,  4'd0,  1'b0, 1'b1, 4'd7,  4'd9,  1'b1, 1'b0, 1'b1);
      vecs[6] = mk(1'b1, 4'd0,  4'd15, 1'b1, 1'b1, 4'd15, 4'd0,  1'b1, 1'b1, 1'b0);
      vecs[7] = mk(1'b0, 4'd0,  4'd0,  1'b0, 1'b1, 4'd15, 4'd0,  1'b1, 1'b0, 1'b1);
      vecs[8] = mk(1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) begin
         bus_a.g_valid = vecs[i].gv; bus_a.g_x = vecs[i].gx; bus_a.g_y = vecs[i].gy;
         bus_a.g_val = vecs[i].gval;
         bus_a.o_valid = vecs[i].ov; bus_a.o_x = vecs[i].ox; bus_a.o_y = vecs[i].oy;
         bus_a.o_val = vecs[i].oval;
         #1;
         chk1("tbl_g_ready", bus_a.g_ready, vecs[i].eg);
         chk1("tbl_o_ready", bus_a.o_ready, vecs[i].eo);
         step();
      end
      idle_a();
      #1 chkg("grid_before_commit", bus_a.grid_out, '0);

      // Commit, frame_done ten cycles later
      exp_grid = '0;
      exp_grid[1][1] = 1'b1; exp_grid[2][2] = 1'b1; exp_grid[3][3] = 1'b1;
      exp_grid[4][4] = 1'b1; exp_grid[5][3] = 1'b1; exp_grid[9][7] = 1'b1;
      exp_grid[15][0] = 1'b1; exp_grid[0][15] = 1'b1;
      bus_a.commit_req = 1'b1;
      step();
      bus_a.commit_req = 1'b0;
      for (int k = 0; k < 9; k++) begin
         #1 chk1("commit_busy", bus_a.busy, 1'b1);
         step();
      end
      bus_a.frame_done = 1'b1;
      step();
      bus_a.frame_done = 1'b0;
      #1;
      chk1("commit_ack_fd", bus_a.commit_ack, 1'b1);
      chkg("grid_after_swap", bus_a.grid_out, exp_grid);
      step();
      #1 chk1("ack_one_cycle", bus_a.commit_ack, 1'b0);

      // Clear and commit together
      bus_a.clear_req = 1'b1; bus_a.commit_req = 1'b1;
      bus_a.g_valid = 1'b1; bus_a.g_x = 4'd6; bus_a.g_y = 4'd6; bus_a.g_val = 1'b1;
      step();
      bus_a.clear_req = 1'b0; bus_a.commit_req = 1'b0;
      for (int k = 0; k < 16; k++) begin
         #1 chk1("clear_no_ready", bus_a.g_ready, 1'b0);
         step();
      end
      bus_a.g_valid = 1'b0;
      #1 chk1("wait_after_clear_busy", bus_a.busy, 1'b1);
      step();
      step();
      bus_a.frame_done = 1'b1;
      step();
      bus_a.frame_done = 1'b0;
      #1;
      chk1("clear_commit_ack", bus_a.commit_ack, 1'b1);
      chkg("grid_cleared", bus_a.grid_out, '0);
      step();

      // Timeout on the short-timeout instance; frame_done on the commit cycle must not count
      @(negedge clk);
      bus_b.g_valid = 1'b1; bus_b.g_x = 4'd9; bus_b.g_y = 4'd2; bus_b.g_val = 1'b1;
      #1 chk1("b_g_ready", bus_b.g_ready, 1'b1);
      @(negedge clk);
      bus_b.g_valid = 1'b0;
      bus_b.commit_req = 1'b1; bus_b.frame_done = 1'b1;
      @(negedge clk);
      bus_b.commit_req = 1'b0; bus_b.frame_done = 1'b0;
      first = -1;
      acks  = 0;
      for (int n = 0; n < 14; n++) begin
         #1;
         if (bus_b.commit_ack) begin
            acks++;
            if (first < 0) first = n;
         end
         @(negedge clk);
      end
      chk1("b_timeout_at_8", first == int'(TMO_B), 1'b1);
      if (first != int'(TMO_B)) $display("FAIL b_timeout_cycle actual=%0d expected=%0d", first, TMO_B);
      chk1("b_single_ack", acks == 1, 1'b1);
      exp_grid = '0;
      exp_grid[2][9] = 1'b1;
      chkg("b_grid", bus_b.grid_out, exp_grid);
      chk1("b_idle", bus_b.busy, 1'b0);

      // Randomized traffic against the model
      idle_a();
      step();
      g_hold = 1'b0;
      o_hold = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         if (!g_hold) begin
            bus_a.g_valid = ($urandom_range(0, 2) != 0);
            bus_a.g_x = 4'($urandom_range(0, 15)); bus_a.g_y = 4'($urandom_range(0, 15));
            bus_a.g_val = 1'($urandom_range(0, 1));
         end
         if (!o_hold) begin
            bus_a.o_valid = ($urandom_range(0, 2) != 0);
            bus_a.o_x = 4'($urandom_range(0, 15)); bus_a.o_y = 4'($urandom_range(0, 15));
            bus_a.o_val = 1'($urandom_range(0, 1));
         end
         bus_a.clear_req  = ($urandom_range(0, 60) == 0);
         bus_a.commit_req = ($urandom_range(0, 15) == 0);
         bus_a.frame_done = ($urandom_range(0, 7) == 0);
         step();
         g_hold = bus_a.g_valid && !eg;
         o_hold = bus_a.o_valid && !eo;
      end
      idle_a();
      bus_a.g_valid = 1'b1; bus_a.g_x = 4'd8; bus_a.g_y = 4'd8; bus_a.g_val = 1'b1;
      bus_a.commit_req = 1'b1;
      step();
      bus_a.commit_req = 1'b0; bus_a.frame_done = 1'b1;
      step();
      idle_a();
      step();

      // Reset in the seventh CLEAR cycle with a commit queued
      bus_a.clear_req = 1'b1; bus_a.commit_req = 1'b1;
      step();
      bus_a.clear_req = 1'b0; bus_a.commit_req = 1'b0;
      repeat (6) step();
      bus_a.g_valid = 1'b1; bus_a.g_x = 4'd5; bus_a.g_y = 4'd5; bus_a.g_val = 1'b1;
      #2 reset = 1'b0;
      #1;
      chk1("midclr_rst_g_ready", bus_a.g_ready, 1'b0);
      chk1("midclr_rst_busy", bus_a.busy, 1'b0);
      chk1("midclr_rst_ack", bus_a.commit_ack, 1'b0);
      chkg("midclr_rst_grid", bus_a.grid_out, '0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      #1 chk1("post_rst_g_ready", bus_a.g_ready, 1'b1);
      step();
      idle_a();
      for (int k = 0; k < 30; k++) begin
         #1 chk1("post_rst_no_ack", bus_a.commit_ack, 1'b0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
